// File: rtl/cpu_pkg.sv
// Shared constants and types for the branch/execute slice of the 5-stage CPU.
package cpu_pkg;

  localparam logic [3:0] OP_B   = 4'b1000;
  localparam logic [3:0] OP_CBZ = 4'b1001;
  localparam logic [3:0] OP_BLT = 4'b1010;

  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;

  typedef struct packed {
    logic n;
    logic z;
    logic o;
    logic c;
  } flags_t;

endpackage

// File: rtl/branch_exec_unit_if.sv
// RF-stage branch inputs, EX-stage ALU inputs and all results of branch_exec_unit.
// Handshake: none; every input is sampled combinationally each cycle, set_flags qualifies the flag load at the next rising edge.
interface branch_exec_unit_if;
  logic [63:0] pc;
  logic [63:0] db;
  logic [3:0]  opcode;
  logic [18:0] imm19;
  logic [25:0] imm26;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [2:0]  alu_op;
  logic        set_flags;
  logic [63:0] alu_out;
  logic        n, z, o, c;
  logic        flag_n, flag_z, flag_o, flag_c;
  logic [63:0] pc_br;
  logic        br_taken;

  modport master (
    output pc, db, opcode, imm19, imm26, alu_a, alu_b, alu_op, set_flags,
    input  alu_out, n, z, o, c, flag_n, flag_z, flag_o, flag_c, pc_br, br_taken
  );

  modport slave (
    input  pc, db, opcode, imm19, imm26, alu_a, alu_b, alu_op, set_flags,
    output alu_out, n, z, o, c, flag_n, flag_z, flag_o, flag_c, pc_br, br_taken
  );
endinterface

// File: rtl/accelerated_branch.sv
// RF-stage branch resolution for B, CBZ and B.LT with target adder.
module accelerated_branch
    import cpu_pkg::*;
(
    input  logic [63:0] pc,
    input  logic [63:0] db,
    input  logic [3:0]  opcode,
    input  logic [18:0] imm19,
    input  logic [25:0] imm26,
    input  logic        use_live,
    input  logic        live_n,
    input  logic        live_o,
    input  logic        flag_n,
    input  logic        flag_o,
    output logic [63:0] pc_br,
    output logic        br_taken
);
    logic [63:0] offset;
    logic        sel_n;
    logic        sel_o;

    assign offset = (opcode == OP_B) ? {{36{imm26[25]}}, imm26, 2'b00}
                                     : {{43{imm19[18]}}, imm19, 2'b00};

    add u_add (.a(pc), .b(offset), .y(pc_br));

    // A flag-setting instruction in EX bypasses the register for B.LT.
    assign sel_n = use_live ? live_n : flag_n;
    assign sel_o = use_live ? live_o : flag_o;

    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            OP_B:    br_taken = 1'b1;
            OP_CBZ:  br_taken = (db == 64'd0);
            OP_BLT:  br_taken = (sel_n != sel_o);
            default: br_taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/add.sv
// 64-bit combinational adder, wraps mod 2^64.
module add (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    assign y = a + b;
endmodule

// File: rtl/alu.sv
// 64-bit ALU with N/Z/O/C flags; subtraction is A + ~B + 1 on the shared adder.
module alu
    import cpu_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [2:0]  op,
    output logic [63:0] y,
    output logic        n,
    output logic        z,
    output logic        o,
    output logic        c
);
    logic [63:0] b_eff;
    logic [63:0] b_add;
    logic [63:0] sum;
    logic        cin;
    logic        is_arith;

    always_comb begin
        b_eff    = b;
        cin      = 1'b0;
        is_arith = 1'b0;
        case (op)
            ALU_ADD: is_arith = 1'b1;
            ALU_SUB: begin
                b_eff    = ~b;
                cin      = 1'b1;
                is_arith = 1'b1;
            end
            default: ;
        endcase
    end

    // Fold the carry-in into operand B; the sum mod 2^64 is unchanged.
    assign b_add = b_eff + {63'd0, cin};

    add u_add (.a(a), .b(b_add), .y(sum));

    always_comb begin
        y = '0;
        case (op)
            ALU_PASSB:        y = b;
            ALU_ADD, ALU_SUB: y = sum;
            ALU_AND:          y = a & b;
            ALU_OR:           y = a | b;
            ALU_XOR:          y = a ^ b;
            default:          y = '0;
        endcase
    end

    assign n = y[63];
    assign z = (y == 64'd0);
    // Carry into bit 63 is y[63]^a[63]^b_eff[63]; carry out is the majority of the three.
    assign c = is_arith & ((a[63] & b_eff[63]) | ((a[63] ^ b_eff[63]) & ~y[63]));
    assign o = is_arith & (a[63] == b_eff[63]) & (y[63] != a[63]);
endmodule

// File: rtl/branch_exec_unit.sv
// Integer execute ALU, condition-flag register and accelerated RF-stage branch unit.
module branch_exec_unit
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    branch_exec_unit_if.slave  bus
);
    flags_t live;
    flags_t flags_q;

    alu u_alu (
        .a  (bus.alu_a),
        .b  (bus.alu_b),
        .op (bus.alu_op),
        .y  (bus.alu_out),
        .n  (live.n),
        .z  (live.z),
        .o  (live.o),
        .c  (live.c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (bus.set_flags) begin
            flags_q <= live;
        end
    end

    accelerated_branch u_br (
        .pc       (bus.pc),
        .db       (bus.db),
        .opcode   (bus.opcode),
        .imm19    (bus.imm19),
        .imm26    (bus.imm26),
        .use_live (bus.set_flags),
        .live_n   (live.n),
        .live_o   (live.o),
        .flag_n   (flags_q.n),
        .flag_o   (flags_q.o),
        .pc_br    (bus.pc_br),
        .br_taken (bus.br_taken)
    );

    assign bus.n      = live.n;
    assign bus.z      = live.z;
    assign bus.o      = live.o;
    assign bus.c      = live.c;
    assign bus.flag_n = flags_q.n;
    assign bus.flag_z = flags_q.z;
    assign bus.flag_o = flags_q.o;
    assign bus.flag_c = flags_q.c;
endmodule

// File: tb/tb_branch_exec_unit.sv
// Directed bench for branch_exec_unit: ALU ops/flags, flag register, branch targets and conditions.
module tb_branch_exec_unit;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  branch_exec_unit_if bus();

  branch_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard-style comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic sf);
    bus.alu_op    = op;
    bus.alu_a     = a;
    bus.alu_b     = b;
    bus.set_flags = sf;
  endtask

  task automatic drive_br(input logic [3:0] opc, input logic [63:0] pc, input logic [63:0] db,
                          input logic [18:0] i19, input logic [25:0] i26);
    bus.opcode = opc;
    bus.pc     = pc;
    bus.db     = db;
    bus.imm19  = i19;
    bus.imm26  = i26;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive_alu(ALU_SUB, 64'd3, 64'd9, 1'b1);
    drive_br(4'b0000, 64'd0, 64'd0, 19'd0, 26'd0);

    // reset has priority over set_flags
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_flag_n", {63'd0, bus.flag_n}, 64'd0);
    check("rst_flag_z", {63'd0, bus.flag_z}, 64'd0);
    check("rst_flag_o", {63'd0, bus.flag_o}, 64'd0);
    check("rst_flag_c", {63'd0, bus.flag_c}, 64'd0);
    check("rst_comb_alu", bus.alu_out, 64'hFFFF_FFFF_FFFF_FFFA);
    reset = 1'b0;
    drive_alu(ALU_PASSB, 64'd0, 64'd0, 1'b0);

    // B with offset -1 word
    drive_br(OP_B, 64'h100, 64'd7, 19'd0, 26'h3FF_FFFF);
    #1;
    check("b_pc_br", bus.pc_br, 64'hFC);
    check("b_taken", {63'd0, bus.br_taken}, 64'd1);

    // B wrap-around
    drive_br(OP_B, 64'd0, 64'd0, 19'd0, 26'h3FF_FFFF);
    #1;
    check("b_wrap", bus.pc_br, 64'hFFFF_FFFF_FFFF_FFFC);

    // CBZ taken / not taken
    drive_br(OP_CBZ, 64'h40, 64'd0, 19'd3, 26'h3FF_FFFF);
    #1;
    check("cbz0_pc_br", bus.pc_br, 64'h4C);
    check("cbz0_taken", {63'd0, bus.br_taken}, 64'd1);
    drive_br(OP_CBZ, 64'h40, 64'd5, 19'd3, 26'd0);
    #1;
    check("cbz5_pc_br", bus.pc_br, 64'h4C);
    check("cbz5_taken", {63'd0, bus.br_taken}, 64'd0);

    // ALU arithmetic and flags
    drive_alu(ALU_SUB, 64'd5, 64'd7, 1'b0);
    #1;
    check("sub57_out", bus.alu_out, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub57_nzoc", {60'd0, bus.n, bus.z, bus.o, bus.c}, 64'b1000);
    drive_alu(ALU_SUB, 64'd7, 64'd7, 1'b0);
    #1;
    check("sub77_out", bus.alu_out, 64'd0);
    check("sub77_nzoc", {60'd0, bus.n, bus.z, bus.o, bus.c}, 64'b0101);
    drive_alu(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    #1;
    check("add_ovf_out", bus.alu_out, 64'h8000_0000_0000_0000);
    check("add_ovf_nzoc", {60'd0, bus.n, bus.z, bus.o, bus.c}, 64'b1010);
    drive_alu(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
    #1;
    check("add_carry_out", bus.alu_out, 64'd1);
    check("add_carry_nzoc", {60'd0, bus.n, bus.z, bus.o, bus.c}, 64'b0001);
    drive_alu(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    #1;
    check("sub_ovf_out", bus.alu_out, 64'h7FFF_FFFF_FFFF_FFFF);
    check("sub_ovf_nzoc", {60'd0, bus.n, bus.z, bus.o, bus.c}, 64'b0011);

    // logic ops clear O/C
    drive_alu(ALU_AND, 64'hF0F0, 64'hFF00, 1'b0);
    #1;
    check("and_out", bus.alu_out, 64'hF000);
    drive_alu(ALU_OR, 64'hF0F0, 64'hFF00, 1'b0);
    #1;
    check("or_out", bus.alu_out, 64'hFFF0);
    drive_alu(ALU_XOR, 64'hF0F0, 64'hFF00, 1'b0);
    #1;
    check("xor_out", bus.alu_out, 64'h0FF0);
    drive_alu(ALU_PASSB, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_1234, 1'b0);
    #1;
    check("passb_out", bus.alu_out, 64'h8000_0000_0000_1234);
    check("passb_nzoc", {60'd0, bus.n, bus.z, bus.o, bus.c}, 64'b1000);
    drive_alu(3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    #1;
    check("rsv7_out", bus.alu_out, 64'd0);
    check("rsv7_nzoc", {60'd0, bus.n, bus.z, bus.o, bus.c}, 64'b0100);
    drive_alu(3'b001, 64'd5, 64'd9, 1'b0);
    #1;
    check("rsv1_out", bus.alu_out, 64'd0);

    // B.LT with cleared flags and no bypass: not taken; negative imm19 target
    drive_br(OP_BLT, 64'h1000, 64'd0, 19'h7FFFE, 26'd0);
    #1;
    check("blt_clear_taken", {63'd0, bus.br_taken}, 64'd0);
    check("blt_pc_br", bus.pc_br, 64'hFF8);

    // SUBS 3-9 in EX with B.LT in RF: bypass
    @(negedge clk);
    drive_alu(ALU_SUB, 64'd3, 64'd9, 1'b1);
    #1;
    check("blt_bypass", {63'd0, bus.br_taken}, 64'd1);
    check("flag_before_edge", {63'd0, bus.flag_n}, 64'd0);
    @(negedge clk);
    drive_alu(ALU_PASSB, 64'd0, 64'd0, 1'b0);
    #1;
    check("flags_latched", {60'd0, bus.flag_n, bus.flag_z, bus.flag_o, bus.flag_c}, 64'b1000);
    check("blt_from_reg", {63'd0, bus.br_taken}, 64'd1);

    // hold when set_flags is low
    @(negedge clk);
    #1;
    check("flags_hold", {60'd0, bus.flag_n, bus.flag_z, bus.flag_o, bus.flag_c}, 64'b1000);

    // live flags that disagree with the register take over when set_flags is high
    drive_alu(ALU_SUB, 64'd7, 64'd7, 1'b1);
    #1;
    check("blt_bypass_nt", {63'd0, bus.br_taken}, 64'd0);
    @(negedge clk);
    drive_alu(ALU_PASSB, 64'd0, 64'd0, 1'b0);
    #1;
    check("flags_sub77", {60'd0, bus.flag_n, bus.flag_z, bus.flag_o, bus.flag_c}, 64'b0101);
    @(negedge clk);
    drive_alu(ALU_SUB, 64'd3, 64'd9, 1'b1);
    @(negedge clk);
    drive_alu(ALU_PASSB, 64'd0, 64'd0, 1'b0);

    // reset mid-stream
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_alu(ALU_XOR, 64'hF0F0, 64'hFF00, 1'b0);
    #1;
    check("rst2_flags", {60'd0, bus.flag_n, bus.flag_z, bus.flag_o, bus.flag_c}, 64'd0);
    check("rst2_blt", {63'd0, bus.br_taken}, 64'd0);

    // non-branch opcode never taken
    drive_br(4'b0010, 64'h40, 64'd0, 19'd3, 26'd1);
    drive_alu(ALU_SUB, 64'd3, 64'd9, 1'b1);
    #1;
    check("nonbr_taken", {63'd0, bus.br_taken}, 64'd0);
    check("nonbr_pc_br", bus.pc_br, 64'h4C);
    bus.set_flags = 1'b0;

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
